mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. Both requesters share one synchronous RAM port through a request/ack handshake. Data accesses win by default, and the execute stage's memory-stall hint can reserve the port ahead of a load or store. A four-state FSM sequences each transaction and registers all bus outputs.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits (guard build only)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_mc_req  in  1  fetch request; held until if_mc_ack
- if_mc_addr  in  32  fetch address
- mc_if_ack  out  1  one-cycle pulse; mc_if_data valid this cycle
- mc_if_data  out  32  fetched word
- mem_mc_req  in  1  data request; held until mc_mem_ack
- mem_mc_write  in  1  1 = store, 0 = load
- mem_mc_addr  in  32  data address
- mem_mc_wdata  in  32  store data
- mc_mem_ack  out  1  one-cycle pulse; mc_mem_rdata valid on loads
- mc_mem_rdata  out  32  loaded word
- ex_mc_reserve  in  1  execute stage has a load or store entering memory next cycle
- mc_ram_req  out  1  RAM access strobe
- mc_ram_write  out  1  RAM write enable
- mc_ram_addr  out  32  RAM address
- mc_ram_wdata  out  32  RAM write data
- ram_mc_ready  in  1  RAM completion; read data valid this cycle
- ram_mc_rdata  in  32  RAM read data

## Operation
- FSM states:
  - IDLE: both acks low.
  - BUSY_IF and BUSY_MEM: RAM transaction in flight.
  - ACK: exactly one ack high.
- IDLE transitions, evaluated each cycle:
  - If mem_mc_req is high, go to BUSY_MEM.
  - Else, if if_mc_req is high and ex_mc_reserve is low, go to BUSY_IF.
  - Otherwise stay in IDLE.
- On entry to a BUSY state:
  - Latch the winner's address, write flag (0 for fetch) and write data into the mc_ram_* registers.
  - Set mc_ram_req = 1.
- BUSY state:
  - Hold all mc_ram_* outputs stable until ram_mc_ready = 1.
  - On the ready cycle: clear mc_ram_req and mc_ram_write, capture ram_mc_rdata into the winner's data register, go to ACK.
- ACK state:
  - Pulse the winner's ack for one cycle.
  - No arbitration happens in ACK; the next state is always IDLE.
  - The requester must drop or renew its request before that IDLE cycle.
- Data registers:
  - mc_if_data and mc_mem_rdata hold their last value between acks.
  - Store transactions leave mc_mem_rdata unchanged.
- If a requester drops its request mid-transaction, the RAM access still completes and the ack is still issued.
- Request inputs are sampled only in IDLE; address and data changes during BUSY are ignored.

## Timing
- Reset values: state IDLE, all acks 0, mc_ram_req 0, mc_ram_write 0, mc_ram_addr 0, mc_ram_wdata 0, mc_if_data 0, mc_mem_rdata 0, starvation counter 0.
- Reset asserted mid-transaction:
  - mc_ram_req drops immediately (asynchronously).
  - The pending transaction is abandoned; no ack is issued.
- Latency, with the request sampled in IDLE at edge N:
  - mc_ram_req is high after edge N.
  - With ready arriving k cycles after that (k ≥ 0), the ack is high in cycle N+k+2.
  - Minimum request-to-ack latency with a zero-wait RAM is 2 cycles.
- Minimum spacing between back-to-back transactions is 3 cycles (BUSY, ACK, IDLE).
- Simultaneous requests in IDLE: the data request wins; the fetch request stays pending.
- ex_mc_reserve blocks only new fetch grants. It never aborts a fetch already in BUSY_IF.

## Configuration
- MC_STARVE_GUARD_EN defined:
  - A 3-bit counter increments on each BUSY_MEM entry made while if_mc_req is high.
  - When the counter equals STARVE_LIMIT and both requests are pending in IDLE, fetch is granted, overriding both data priority and ex_mc_reserve.
  - The counter clears on every BUSY_IF entry.
- MC_STARVE_GUARD_EN undefined:
  - No counter is built; data priority is strict.
  - Fetch can starve indefinitely.

## Test plan
- Fetch only, zero-wait RAM: if_mc_req=1 with address 0x0000_0040, RAM returns 0xDEAD_BEEF with ready in the first BUSY cycle -> mc_if_ack pulses 2 cycles after the sampling edge with mc_if_data=0xDEAD_BEEF; mc_ram_write stays 0.
- Simultaneous requests: fetch and a store (address 0x100, data 0x1234_5678) raised in the same cycle -> store is served first (mc_ram_write=1, wdata 0x1234_5678), then the fetch; exactly one ack per request.
- Reserve: ex_mc_reserve=1 with only a fetch pending for 3 cycles -> no mc_ram_req during those cycles; fetch granted in the first IDLE cycle after reserve falls.
- Wait states: load with ready delayed 5 cycles -> mc_ram_addr stable across all BUSY cycles; mc_mem_ack arrives 7 cycles after the sampling edge with the correct rdata.
- Reset mid-BUSY: reset taken low during a 4-wait-state load -> mc_ram_req drops immediately; no ack follows; after release the FSM accepts a fresh request normally.
- Starvation (guard build, STARVE_LIMIT=4): data requests held continuously with a fetch pending -> 4 data grants, then the fetch is granted; without the macro, the fetch is never granted.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/ack bundle for the fetch/data memory arbiter and its shared RAM port.
// master = arbiter side, slave = requesters and RAM side.
interface mem_arbiter_if;
    logic        if_mc_req;
    logic [31:0] if_mc_addr;
    logic        mc_if_ack;
    logic [31:0] mc_if_data;

    logic        mem_mc_req;
    logic        mem_mc_write;
    logic [31:0] mem_mc_addr;
    logic [31:0] mem_mc_wdata;
    logic        mc_mem_ack;
    logic [31:0] mc_mem_rdata;

    logic        ex_mc_reserve;

    logic        mc_ram_req;
    logic        mc_ram_write;
    logic [31:0] mc_ram_addr;
    logic [31:0] mc_ram_wdata;
    logic        ram_mc_ready;
    logic [31:0] ram_mc_rdata;

    modport master (
        input  if_mc_req, if_mc_addr,
        output mc_if_ack, mc_if_data,
        input  mem_mc_req, mem_mc_write, mem_mc_addr, mem_mc_wdata,
        output mc_mem_ack, mc_mem_rdata,
        input  ex_mc_reserve,
        output mc_ram_req, mc_ram_write, mc_ram_addr, mc_ram_wdata,
        input  ram_mc_ready, ram_mc_rdata
    );

    modport slave (
        output if_mc_req, if_mc_addr,
        input  mc_if_ack, mc_if_data,
        output mem_mc_req, mem_mc_write, mem_mc_addr, mem_mc_wdata,
        input  mc_mem_ack, mc_mem_rdata,
        output ex_mc_reserve,
        input  mc_ram_req, mc_ram_write, mc_ram_addr, mc_ram_wdata,
        output ram_mc_ready, ram_mc_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win, fetch waits; all bus outputs registered.
// Defining MC_STARVE_GUARD_EN builds the fetch starvation guard (STARVE_LIMIT).
//
// state    | meaning
// IDLE     | no access in flight, acks low, arbitration each cycle
// BUSY_IF  | fetch RAM access in flight
// BUSY_MEM | data RAM access in flight
// ACK      | winner's ack high for this one cycle
module mem_arbiter
`ifdef MC_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input logic           clock,
    input logic           reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, ACK} state_t;

    state_t      state_q, state_d;
    logic        ram_req_d, ram_write_d;
    logic [31:0] ram_addr_d, ram_wdata_d;
    logic        if_ack_d, mem_ack_d;
    logic [31:0] if_data_d, mem_rdata_d;
    logic        starve;
    logic        grant_mem, grant_if;

`ifdef MC_STARVE_GUARD_EN
    logic [2:0] starve_cnt_q;

    assign starve = (starve_cnt_q == 3'(STARVE_LIMIT)) && bus.if_mc_req && bus.mem_mc_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (grant_if)
                starve_cnt_q <= '0;
            else if (grant_mem && bus.if_mc_req)
                starve_cnt_q <= starve_cnt_q + 3'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // A forced fetch overrides both data priority and the reserve hint.
    assign grant_mem = bus.mem_mc_req && !starve;
    assign grant_if  = bus.if_mc_req && (starve || (!bus.mem_mc_req && !bus.ex_mc_reserve));

    always_comb begin
        state_d     = state_q;
        ram_req_d   = bus.mc_ram_req;
        ram_write_d = bus.mc_ram_write;
        ram_addr_d  = bus.mc_ram_addr;
        ram_wdata_d = bus.mc_ram_wdata;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_data_d   = bus.mc_if_data;
        mem_rdata_d = bus.mc_mem_rdata;
        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d     = BUSY_MEM;
                    ram_req_d   = 1'b1;
                    ram_write_d = bus.mem_mc_write;
                    ram_addr_d  = bus.mem_mc_addr;
                    ram_wdata_d = bus.mem_mc_wdata;
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    ram_req_d   = 1'b1;
                    ram_write_d = 1'b0;
                    ram_addr_d  = bus.if_mc_addr;
                    ram_wdata_d = '0;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (bus.ram_mc_ready) begin
                    state_d     = ACK;
                    ram_req_d   = 1'b0;
                    ram_write_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_ack_d  = 1'b1;
                        if_data_d = bus.ram_mc_rdata;
                    end else begin
                        mem_ack_d = 1'b1;
                        // mc_ram_write still holds the latched flag: stores keep old rdata
                        if (!bus.mc_ram_write)
                            mem_rdata_d = bus.ram_mc_rdata;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mc_ram_req   <= 1'b0;
            bus.mc_ram_write <= 1'b0;
            bus.mc_ram_addr  <= '0;
            bus.mc_ram_wdata <= '0;
            bus.mc_if_ack    <= 1'b0;
            bus.mc_mem_ack   <= 1'b0;
            bus.mc_if_data   <= '0;
            bus.mc_mem_rdata <= '0;
        end else begin
            bus.mc_ram_req   <= ram_req_d;
            bus.mc_ram_write <= ram_write_d;
            bus.mc_ram_addr  <= ram_addr_d;
            bus.mc_ram_wdata <= ram_wdata_d;
            bus.mc_if_ack    <= if_ack_d;
            bus.mc_mem_ack   <= mem_ack_d;
            bus.mc_if_data   <= if_data_d;
            bus.mc_mem_rdata <= mem_rdata_d;
        end
    end
endmodule
